// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage floating-point multiplier, RNE rounding, subnormals flushed.
// Define FP_MULT_FLAGS_EN to add the {invalid,overflow,underflow,inexact} flags port.
module fp_mult_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] x,
   input  logic [EXP_W+MAN_W:0] y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result
`ifdef FP_MULT_FLAGS_EN
   ,
   output logic [3:0]           flags
`endif
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 1;
   localparam int PW = 2 * SW;
   localparam int XW = EXP_W + 2;
   localparam logic [XW-1:0] BIAS = XW'(2**(EXP_W-1) - 1);
   localparam logic [XW-1:0] EMAX = XW'(2**EXP_W - 1);
   localparam logic [EXP_W-1:0] EONES = '1;
   localparam logic [W-1:0] QNAN = {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};

   logic stall;
   logic s1_v_q, s2_v_q, s3_v_q;

   assign stall     = s3_v_q & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = s3_v_q;

   // ---------------- S1: unpack / classify ----------------
   logic             sx, sy;
   logic [EXP_W-1:0] ex, ey;
   logic [MAN_W-1:0] mx, my;
   logic             zx, zy, infx, infy, nanx, nany;

   assign {sx, ex, mx} = x;
   assign {sy, ey, my} = y;
   assign zx   = (ex == '0);
   assign zy   = (ey == '0);
   assign infx = (ex == EONES) & (mx == '0);
   assign infy = (ey == EONES) & (my == '0);
   assign nanx = (ex == EONES) & (mx != '0);
   assign nany = (ey == EONES) & (my != '0);

   logic          s1_s_d;
   logic [XW-1:0] s1_e_d;
   logic          s1_sp_d;
   logic [W-1:0]  s1_spr_d;
`ifdef FP_MULT_FLAGS_EN
   logic [3:0]    s1_spf_d;
`endif

   assign s1_s_d = sx ^ sy;
   assign s1_e_d = {2'b00, ex} + {2'b00, ey} - BIAS;

   // Special operands bypass the datapath with a precomputed result
   always_comb begin
      s1_sp_d  = 1'b1;
      s1_spr_d = '0;
`ifdef FP_MULT_FLAGS_EN
      s1_spf_d = '0;
`endif
      if (nanx | nany) begin
         s1_spr_d = QNAN;
`ifdef FP_MULT_FLAGS_EN
         s1_spf_d = {(nanx & ~mx[MAN_W-1]) | (nany & ~my[MAN_W-1]), 3'b000};
`endif
      end else if ((infx & zy) | (zx & infy)) begin
         s1_spr_d = QNAN;
`ifdef FP_MULT_FLAGS_EN
         s1_spf_d = 4'b1000;
`endif
      end else if (infx | infy) begin
         s1_spr_d = {s1_s_d, EONES, {MAN_W{1'b0}}};
      end else if (zx | zy) begin
         s1_spr_d = {s1_s_d, {(W-1){1'b0}}};
      end else begin
         s1_sp_d = 1'b0;
      end
   end

   logic          s1_s_q;
   logic [XW-1:0] s1_e_q;
   logic [SW-1:0] s1_ma_q, s1_mb_q;
   logic          s1_sp_q;
   logic [W-1:0]  s1_spr_q;
`ifdef FP_MULT_FLAGS_EN
   logic [3:0]    s1_spf_q;
`endif

   // S1 register: captures the classified operand pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q   <= 1'b0;
         s1_s_q   <= 1'b0;
         s1_e_q   <= '0;
         s1_ma_q  <= '0;
         s1_mb_q  <= '0;
         s1_sp_q  <= 1'b0;
         s1_spr_q <= '0;
`ifdef FP_MULT_FLAGS_EN
         s1_spf_q <= '0;
`endif
      end else if (!stall) begin
         s1_v_q   <= in_valid;
         s1_s_q   <= s1_s_d;
         s1_e_q   <= s1_e_d;
         s1_ma_q  <= {1'b1, mx};
         s1_mb_q  <= {1'b1, my};
         s1_sp_q  <= s1_sp_d;
         s1_spr_q <= s1_spr_d;
`ifdef FP_MULT_FLAGS_EN
         s1_spf_q <= s1_spf_d;
`endif
      end
   end

   // ---------------- S2: significand multiply ----------------
   logic [PW-1:0] s2_p_d;

   assign s2_p_d = {{SW{1'b0}}, s1_ma_q} * {{SW{1'b0}}, s1_mb_q};

   logic          s2_s_q;
   logic [XW-1:0] s2_e_q;
   logic [PW-1:0] s2_p_q;
   logic          s2_sp_q;
   logic [W-1:0]  s2_spr_q;
`ifdef FP_MULT_FLAGS_EN
   logic [3:0]    s2_spf_q;
`endif

   // S2 register: raw product plus carried-along control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q   <= 1'b0;
         s2_s_q   <= 1'b0;
         s2_e_q   <= '0;
         s2_p_q   <= '0;
         s2_sp_q  <= 1'b0;
         s2_spr_q <= '0;
`ifdef FP_MULT_FLAGS_EN
         s2_spf_q <= '0;
`endif
      end else if (!stall) begin
         s2_v_q   <= s1_v_q;
         s2_s_q   <= s1_s_q;
         s2_e_q   <= s1_e_q;
         s2_p_q   <= s2_p_d;
         s2_sp_q  <= s1_sp_q;
         s2_spr_q <= s1_spr_q;
`ifdef FP_MULT_FLAGS_EN
         s2_spf_q <= s1_spf_q;
`endif
      end
   end

   // ---------------- S3: normalise / round / pack ----------------
   logic             msb, grd, stk, rnd, cry, ovf, unf;
   logic [SW-1:0]    man_n;
   logic [SW:0]      man_r;
   logic [MAN_W-1:0] frac;
   logic [XW-1:0]    e_f;
   logic [W-1:0]     s3_r_d;

   assign msb   = s2_p_q[PW-1];
   assign man_n = msb ? s2_p_q[PW-1 -: SW] : s2_p_q[PW-2 -: SW];
   assign grd   = msb ? s2_p_q[MAN_W] : s2_p_q[MAN_W-1];
   assign stk   = msb ? |s2_p_q[MAN_W-1:0] : |s2_p_q[MAN_W-2:0];
   assign rnd   = grd & (stk | man_n[0]);
   assign man_r = {1'b0, man_n} + (SW+1)'(rnd);
   assign cry   = man_r[SW];
   assign frac  = cry ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
   assign e_f   = s2_e_q + XW'(msb) + XW'(cry);
   assign ovf   = ~e_f[XW-1] & (e_f >= EMAX);
   assign unf   = e_f[XW-1] | (e_f == '0);

   // Select between bypassed special, saturated and normal results
   always_comb begin
      s3_r_d = {s2_s_q, e_f[EXP_W-1:0], frac};
      if (s2_sp_q)
         s3_r_d = s2_spr_q;
      else if (ovf)
         s3_r_d = {s2_s_q, EONES, {MAN_W{1'b0}}};
      else if (unf)
         s3_r_d = {s2_s_q, {(W-1){1'b0}}};
   end

`ifdef FP_MULT_FLAGS_EN
   logic [3:0] s3_f_d;
   logic [3:0] s3_f_q;

   // Exception flags travel with their result
   always_comb begin
      s3_f_d = {3'b000, grd | stk};
      if (s2_sp_q)
         s3_f_d = s2_spf_q;
      else if (ovf)
         s3_f_d = 4'b0101;
      else if (unf)
         s3_f_d = 4'b0011;
   end

   // Flag output register, held with the result on stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         s3_f_q <= '0;
      else if (!stall)
         s3_f_q <= s3_f_d;
   end

   assign flags = s3_f_q;
`endif

   logic [W-1:0] s3_r_q;

   // Output register: result held stable while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_v_q <= 1'b0;
         s3_r_q <= '0;
      end else if (!stall) begin
         s3_v_q <= s2_v_q;
         s3_r_q <= s3_r_d;
      end
   end

   assign result = s3_r_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed-vector bench for fp_mult_pipe (single and half formats).
// Flag checks are active when FP_MULT_FLAGS_EN is defined.
module tb_fp_mult_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] x, y, result;
   logic [3:0]  flags_w;
   logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
   logic [15:0] hx, hy, h_result;
   logic [3:0]  h_flags;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   fp_mult_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
`ifdef FP_MULT_FLAGS_EN
      ,
      .flags     (flags_w)
`endif
   );

   fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (h_in_valid),
      .in_ready  (h_in_ready),
      .x         (hx),
      .y         (hy),
      .out_valid (h_out_valid),
      .out_ready (h_out_ready),
      .result    (h_result)
`ifdef FP_MULT_FLAGS_EN
      ,
      .flags     (h_flags)
`endif
   );

`ifndef FP_MULT_FLAGS_EN
   assign flags_w = 4'b0000;
   assign h_flags = 4'b0000;
`endif

   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] f,
                        output int lat);
      @(negedge clk);
      x = a;
      y = b;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      r = result;
      f = flags_w;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      x = '0;
      y = '0;
      h_in_valid = 1'b0;
      h_out_ready = 1'b1;
      hx = '0;
      hy = '0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      n_vec++;
      if (result !== 32'h0) begin
         n_err++;
         $display("FAIL reset_result: got %h expected 00000000", result);
      end
`ifdef FP_MULT_FLAGS_EN
      n_vec++;
      if (flags_w !== 4'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b expected 0000", flags_w);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_table(input string tag, input int n,
                             input logic [31:0] ta [8], input logic [31:0] tb [8],
                             input logic [31:0] te [8], input logic [3:0] tf [8]);
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
      for (int i = 0; i < n; i++) begin
         issue(ta[i], tb[i], r, f, lat);
         n_vec++;
         if (r !== te[i]) begin
            n_err++;
            $display("FAIL %s[%0d] result: got %h expected %h", tag, i, r, te[i]);
         end
         n_vec++;
         if (lat !== 3) begin
            n_err++;
            $display("FAIL %s[%0d] latency: got %0d expected 3", tag, i, lat);
         end
`ifdef FP_MULT_FLAGS_EN
         n_vec++;
         if (f !== tf[i]) begin
            n_err++;
            $display("FAIL %s[%0d] flags: got %b expected %b", tag, i, f, tf[i]);
         end
`endif
      end
   endtask

   task automatic test_arith;
      logic [31:0] ta [8] = '{32'h45800000, 32'h3FC00000, 32'h3F800001,
                              32'h3F800001, 32'h3F800003, 32'h3FFFFFFF,
                              32'hC0000000, 32'h7F000000};
      logic [31:0] tb [8] = '{32'h45800000, 32'h3FC00000, 32'h3F800001,
                              32'h3FC00000, 32'h3FC00000, 32'h3F800001,
                              32'h40400000, 32'h3FFFFFFF};
      logic [31:0] te [8] = '{32'h4B800000, 32'h40100000, 32'h3F800002,
                              32'h3FC00002, 32'h3FC00004, 32'h40000000,
                              32'hC0C00000, 32'h7F7FFFFF};
      logic [3:0]  tf [8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                              4'b0001, 4'b0001, 4'b0000, 4'b0000};
      test_table("arith", 8, ta, tb, te, tf);
   endtask

   task automatic test_special;
      logic [31:0] ta [8] = '{32'h7F800000, 32'hFF800000, 32'h80000000,
                              32'h7FC00001, 32'hFF800001, 32'h7F800000,
                              32'h00400000, 32'h40000000};
      logic [31:0] tb [8] = '{32'h00000000, 32'h40000000, 32'h40000000,
                              32'h3F800000, 32'h3F800000, 32'hFF800000,
                              32'hBF800000, 32'h00000000};
      logic [31:0] te [8] = '{32'h7FC00000, 32'hFF800000, 32'h80000000,
                              32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                              32'h80000000, 32'h00000000};
      logic [3:0]  tf [8] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000,
                              4'b1000, 4'b0000, 4'b0000, 4'b0000};
      test_table("special", 8, ta, tb, te, tf);
   endtask

   task automatic test_range;
      logic [31:0] ta [8] = '{32'h7F000000, 32'h00800000, 32'h80800000,
                              32'h7F000000, 32'h00800000, 32'h0, 32'h0, 32'h0};
      logic [31:0] tb [8] = '{32'h7F000000, 32'h3F000000, 32'h3F000000,
                              32'hC0000000, 32'h3F800000, 32'h0, 32'h0, 32'h0};
      logic [31:0] te [8] = '{32'h7F800000, 32'h00000000, 32'h80000000,
                              32'hFF800000, 32'h00800000, 32'h0, 32'h0, 32'h0};
      logic [3:0]  tf [8] = '{4'b0101, 4'b0011, 4'b0011, 4'b0101,
                              4'b0000, 4'b0, 4'b0, 4'b0};
      test_table("range", 5, ta, tb, te, tf);
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp_r [8];
      logic [31:0] held;
      logic        holding;
      int          sent, got, stall_cyc, extra;
      sent = 0;
      got = 0;
      stall_cyc = 0;
      extra = 0;
      holding = 1'b0;
      held = '0;
      for (int i = 0; i < 8; i++) exp_r[i] = 32'h40000000 + i;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 6 && cyc < 10);
         in_valid = (sent < 8);
         x = 32'h3F800000 + sent;
         y = 32'h40000000;
         #1;
         if (out_valid && !out_ready) begin
            stall_cyc++;
            n_vec++;
            if (in_ready !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_stall_in_ready: got %b expected 0", in_ready);
            end
            if (holding) begin
               n_vec++;
               if (result !== held) begin
                  n_err++;
                  $display("FAIL b2b_hold: got %h expected %h", result, held);
               end
            end
            held = result;
            holding = 1'b1;
         end else begin
            holding = 1'b0;
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            n_vec++;
            if (result !== exp_r[got]) begin
               n_err++;
               $display("FAIL b2b_result[%0d]: got %h expected %h", got, result, exp_r[got]);
            end
            got++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      n_vec++;
      if (got !== 8) begin
         n_err++;
         $display("FAIL b2b_count: got %0d expected 8", got);
      end
      n_vec++;
      if (stall_cyc !== 4) begin
         n_err++;
         $display("FAIL b2b_stall_cycles: got %0d expected 4", stall_cyc);
      end
      n_vec++;
      if (extra !== 0) begin
         n_err++;
         $display("FAIL b2b_extra: got %0d expected 0", extra);
      end
   endtask

   task automatic test_reset_inflight;
      logic [31:0] r;
      logic [3:0]  f;
      int          lat, seen;
      seen = 0;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      x = 32'h3F800000;
      y = 32'h40000000;
      @(negedge clk);
      x = 32'h40000000;
      y = 32'h40000000;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rst_pre_out_valid: got %b expected 1", out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rst_async_out_valid: got %b expected 0", out_valid);
      end
      n_vec++;
      if (result !== 32'h0) begin
         n_err++;
         $display("FAIL rst_async_result: got %h expected 00000000", result);
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_async_in_ready: got %b expected 1", in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_vec++;
      if (seen !== 0) begin
         n_err++;
         $display("FAIL rst_ghost_results: got %0d expected 0", seen);
      end
      issue(32'h40400000, 32'h40000000, r, f, lat);
      n_vec++;
      if (r !== 32'h40C00000) begin
         n_err++;
         $display("FAIL rst_first_result: got %h expected 40C00000", r);
      end
      n_vec++;
      if (lat !== 3) begin
         n_err++;
         $display("FAIL rst_first_latency: got %0d expected 3", lat);
      end
   endtask

   task automatic test_half;
      logic [15:0] ha [2] = '{16'h3E00, 16'h3C00};
      logic [15:0] hb [2] = '{16'h3E00, 16'hC000};
      logic [15:0] he [2] = '{16'h4080, 16'hC000};
      int          lat;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         h_out_ready = 1'b1;
         h_in_valid = 1'b1;
         hx = ha[i];
         hy = hb[i];
         @(negedge clk);
         h_in_valid = 1'b0;
         lat = 1;
         while (!h_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         n_vec++;
         if (h_result !== he[i]) begin
            n_err++;
            $display("FAIL half[%0d] result: got %h expected %h", i, h_result, he[i]);
         end
         n_vec++;
         if (lat !== 3) begin
            n_err++;
            $display("FAIL half[%0d] latency: got %0d expected 3", i, lat);
         end
`ifdef FP_MULT_FLAGS_EN
         n_vec++;
         if (h_flags !== 4'b0000) begin
            n_err++;
            $display("FAIL half[%0d] flags: got %b expected 0000", i, h_flags);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_special();
      test_range();
      test_back_to_back();
      test_reset_inflight();
      test_half();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
